// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the 8088 memory-bus responder.
package mem_bus_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic {leer = 1'b0, escribir = 1'b0 + 1'b1} operacion;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} resp_state_t;

endpackage

// File: rtl/mem_word_array.sv
// Single-port 16-bit word RAM; write and read both take effect on the rising edge.
// Read data is registered (one-cycle latency); no backpressure, no reset of contents.
module mem_word_array
  import mem_bus_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the 8088 bus: one request at a time, WAIT_STATES+1 edges to ready,
// initiator holds req until ready; optional MEM_RESP_STATS_EN adds rd_count/wr_count.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int              ADDR_BITS   = 10,
  parameter int              WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] OOR_RDATA = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              RD_WR,
  input  logic [ADDR_W-1:0] Direction,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_oe,
  output logic              ready,
  output logic              err
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  resp_state_t          state_q, state_d;
  logic [3:0]           cnt_q;
  operacion             op_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 oor_q;
  logic [DATA_W-1:0]    ram_rdata;
  logic                 ram_we;
  logic                 access;
  logic [ADDR_W-1:0]    addr_hi;
  logic                 oor_in;
  logic                 unused_addr_lsb;

  // Anything above the word index makes the access out of range.
  assign addr_hi         = Direction >> (ADDR_BITS + 1);
  assign oor_in          = |addr_hi;
  assign unused_addr_lsb = Direction[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= leer;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        op_q    <= operacion'(RD_WR);
        addr_q  <= Direction[ADDR_BITS:1];
        wdata_q <= Data_in;
        oor_q   <= oor_in;
        cnt_q   <= 4'(WAIT_STATES);
      end else if (state_q == WAIT && req && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    access   = 1'b0;
    ready    = 1'b0;
    err      = 1'b0;
    Data_oe  = 1'b0;
    Data_out = '0;
    case (state_q)
      IDLE: if (req) state_d = WAIT;
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ready   = 1'b1;
        err     = oor_q;
        if (op_q == leer) begin
          Data_oe  = 1'b1;
          Data_out = oor_q ? OOR_RDATA : ram_rdata;
        end
        state_d = HOLD;
      end
      HOLD: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A reset landing on the commit edge must not let the write through.
  assign ram_we = access && (op_q == escribir) && !oor_q && !reset;

  mem_word_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (access && !oor_q) begin
      if (op_q == escribir) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder (ADDR_BITS=10, WAIT_STATES=2).
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        RD_WR;
  logic [19:0] Direction;
  logic [15:0] Data_in;
  logic [15:0] Data_out;
  logic        Data_oe;
  logic        ready;
  logic        err;
`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.ADDR_BITS(10), .WAIT_STATES(2), .OOR_RDATA(16'hFFFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .RD_WR     (RD_WR),
    .Direction (Direction),
    .Data_in   (Data_in),
    .Data_out  (Data_out),
    .Data_oe   (Data_oe),
    .ready     (ready),
    .err       (err)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one full handshake; scrambles the bus after acceptance to prove inputs are latched.
  task automatic do_txn(input logic wr, input logic [19:0] dir, input logic [15:0] wd,
                        output int lat, output logic [15:0] dout, output logic oe,
                        output logic er);
    @(negedge clk);
    req = 1'b1; RD_WR = wr; Direction = dir; Data_in = wd;
    lat = -1; dout = '0; oe = 1'b0; er = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i - 1; dout = Data_out; oe = Data_oe; er = err;
      end
      if (i == 1) begin
        Data_in = ~wd; Direction = dir ^ 20'h00004; RD_WR = ~wr;
      end
    end
    @(negedge clk);
    chk("pulse_ready_low", {31'd0, ready}, 32'd0);
    chk("pulse_oe_low", {31'd0, Data_oe}, 32'd0);
    req = 1'b0;
    if (lat >= 0 && dir[19:11] == 9'd0) begin
      if (wr) exp_wr++;
      else exp_rd++;
    end
  endtask

  int          lat;
  logic [15:0] dout;
  logic        oe;
  logic        er;
  int          pulses;

  initial begin
    reset = 1'b1; req = 1'b0; RD_WR = 1'b0; Direction = '0; Data_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_oe", {31'd0, Data_oe}, 32'd0);
    chk("rst_dout", {16'd0, Data_out}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Write then read, including odd byte address aliasing to the same word
    do_txn(1'b1, 20'h00010, 16'hBEEF, lat, dout, oe, er);
    chk("wr_latency", lat, 32'd3);
    chk("wr_err", {31'd0, er}, 32'd0);
    chk("wr_oe", {31'd0, oe}, 32'd0);
    do_txn(1'b0, 20'h00010, 16'h0000, lat, dout, oe, er);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data", {16'd0, dout}, 32'h0000BEEF);
    chk("rd_oe", {31'd0, oe}, 32'd1);
    chk("rd_err", {31'd0, er}, 32'd0);
    do_txn(1'b0, 20'h00011, 16'h0000, lat, dout, oe, er);
    chk("rd_odd_byte", {16'd0, dout}, 32'h0000BEEF);

    // Range boundaries
    do_txn(1'b1, 20'h00000, 16'h5A5A, lat, dout, oe, er);
    do_txn(1'b1, 20'h007FE, 16'h7777, lat, dout, oe, er);
    chk("top_word_wr_err", {31'd0, er}, 32'd0);
    do_txn(1'b0, 20'h007FE, 16'h0000, lat, dout, oe, er);
    chk("top_word_rd", {16'd0, dout}, 32'h00007777);
    do_txn(1'b1, 20'h80000, 16'h1234, lat, dout, oe, er);
    chk("oor_wr_latency", lat, 32'd3);
    chk("oor_wr_err", {31'd0, er}, 32'd1);
    do_txn(1'b1, 20'h00800, 16'h4321, lat, dout, oe, er);
    chk("oor_wr_800_err", {31'd0, er}, 32'd1);
    do_txn(1'b0, 20'h80000, 16'h0000, lat, dout, oe, er);
    chk("oor_rd_data", {16'd0, dout}, 32'h0000FFFF);
    chk("oor_rd_err", {31'd0, er}, 32'd1);
    chk("oor_rd_oe", {31'd0, oe}, 32'd1);
    do_txn(1'b0, 20'h00000, 16'h0000, lat, dout, oe, er);
    chk("word0_intact", {16'd0, dout}, 32'h00005A5A);
    chk("word0_err", {31'd0, er}, 32'd0);

    // Abort after one cycle of WAIT
    @(negedge clk);
    req = 1'b1; RD_WR = 1'b1; Direction = 20'h00010; Data_in = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("abort_no_ready", pulses, 32'd0);
    do_txn(1'b0, 20'h00010, 16'h0000, lat, dout, oe, er);
    chk("abort_no_write", {16'd0, dout}, 32'h0000BEEF);

    // Reset landing on the commit edge
    do_txn(1'b1, 20'h00020, 16'h1111, lat, dout, oe, er);
    @(negedge clk);
    req = 1'b1; RD_WR = 1'b1; Direction = 20'h00020; Data_in = 16'h2222;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_oe", {31'd0, Data_oe}, 32'd0);
    chk("midrst_dout", {16'd0, Data_out}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    reset = 1'b0; req = 1'b0;
`ifdef MEM_RESP_STATS_EN
    chk("midrst_rd_count", {16'd0, rd_count}, 32'd0);
    chk("midrst_wr_count", {16'd0, wr_count}, 32'd0);
    exp_rd = 0; exp_wr = 0;
`endif
    do_txn(1'b0, 20'h00020, 16'h0000, lat, dout, oe, er);
    chk("midrst_no_write", {16'd0, dout}, 32'h00001111);

    // req held through HOLD gives one pulse; re-raising starts a new one
    @(negedge clk);
    req = 1'b1; RD_WR = 1'b0; Direction = 20'h00010;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("hold_one_pulse", pulses, 32'd1);
    req = 1'b0;
    exp_rd++;
    @(negedge clk);
    do_txn(1'b0, 20'h00010, 16'h0000, lat, dout, oe, er);
    chk("hold_second_latency", lat, 32'd3);
    chk("hold_second_data", {16'd0, dout}, 32'h0000BEEF);

`ifdef MEM_RESP_STATS_EN
    @(negedge clk);
    chk("stats_rd_count", {16'd0, rd_count}, exp_rd);
    chk("stats_wr_count", {16'd0, wr_count}, exp_wr);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
